meas_frame_streamer: RTL and testbench

MEAS_FRAME_STREAMER -- requirements
Module: meas_frame_streamer

---
 rtl/meas_frame_streamer.sv | 170 +++++++++++++++++
 tb/tb_meas_frame_streamer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/meas_frame_streamer.sv
// Packs tick-triggered measurement sets (header, counter, data words) into a framed 32-bit stream.
// Latency: tick edge T -> header valid after edge T+2; one word written per cycle while framing.
// Backpressure: frames are admitted only if the whole frame fits in the FIFO, otherwise dropped and counted.
module meas_frame_streamer #(
   parameter int NUM_WORDS  = 8,
   parameter int FIFO_WORDS = 64
) (
   input  logic                          clk_i,
   input  logic                          reset,
   input  logic                          tick_i,
   input  logic [31:0]                   counter_i,
   input  logic [32*NUM_WORDS-1:0]       data_i,
   output logic [31:0]                   m_data_o,
   output logic                          m_valid_o,
   input  logic                          m_ready_i,
   output logic                          m_last_o,
   input  logic                          clear_i,
   output logic                          overflow_o,
   output logic [15:0]                   dropped_o,
   output logic [$clog2(FIFO_WORDS):0]   level_o
);

   localparam int FRAME_LEN = NUM_WORDS + 2;
   localparam int PTR_W     = $clog2(FIFO_WORDS);
   localparam int LVL_W     = PTR_W + 1;
   localparam int IDX_W     = $clog2(FRAME_LEN);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
   localparam logic [LVL_W-1:0] FRAME_LVL = LVL_W'(FRAME_LEN);
   localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_WORDS);
   localparam logic [7:0]       NW8       = 8'(NUM_WORDS);

   // One FIFO entry: stream word plus its end-of-frame marker.
   typedef struct packed {
      logic        last;
      logic [31:0] dat;
   } word_t;

   typedef enum logic {IDLE, WRITE} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q;
   logic [15:0]      seq_q;
   logic [31:0]      frame_q [FRAME_LEN];

   word_t            mem_q [FIFO_WORDS];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
   logic [LVL_W-1:0] level_q, remain;

   logic             space_ok, accept, drop, push, pop;
   word_t            push_word;

   // The whole frame must fit at the tick; this alone keeps the FIFO from overflowing.
   assign space_ok = (DEPTH_LVL - level_q) >= FRAME_LVL;

   // Write FSM: admit or drop ticks, then stream the captured frame one word per cycle.
   always_comb begin
      state_d       = state_q;
      accept        = 1'b0;
      drop          = 1'b0;
      push          = 1'b0;
      push_word.dat = frame_q[idx_q];
      push_word.last = 1'b0;
      case (state_q)
         IDLE: begin
            if (tick_i) begin
               if (space_ok) begin
                  accept  = 1'b1;
                  state_d = WRITE;
               end else begin
                  drop = 1'b1;
               end
            end
         end
         WRITE: begin
            push           = 1'b1;
            push_word.last = (idx_q == LAST_IDX);
            drop           = tick_i;
            if (idx_q == LAST_IDX) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state, word index and sequence number.
   always_ff @(posedge clk_i) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         seq_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            idx_q <= '0;
            seq_q <= seq_q + 16'd1;
         end else if (push) begin
            idx_q <= idx_q + IDX_W'(1);
         end
      end
   end

   // Snapshot of the frame taken at the accepted tick so inputs may change while writing.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         frame_q[0] <= {8'hA5, NW8, seq_q};
         frame_q[1] <= counter_i;
         for (int k = 0; k < NUM_WORDS; k++) begin
            frame_q[k+2] <= data_i[32*k +: 32];
         end
      end
   end

   assign pop        = m_valid_o & m_ready_i;
   assign rd_ptr_nxt = rd_ptr_q + PTR_W'(pop);
   assign remain     = level_q - LVL_W'(pop);

   // FIFO storage; entries need no reset since level/pointers define what is valid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_word;
      end
   end

   // FIFO bookkeeping and registered head: a word becomes visible one edge after it is written.
   always_ff @(posedge clk_i) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         m_valid_o <= 1'b0;
         m_data_o  <= '0;
         m_last_o  <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_q + PTR_W'(push);
         rd_ptr_q  <= rd_ptr_nxt;
         level_q   <= remain + LVL_W'(push);
         // Only words already stored before this edge may be presented next cycle.
         m_valid_o <= (remain != '0);
         if (remain != '0) begin
            m_data_o <= mem_q[rd_ptr_nxt].dat;
            m_last_o <= mem_q[rd_ptr_nxt].last;
         end else begin
            m_last_o <= 1'b0;
         end
      end
   end

   // Drop statistics; a drop coinciding with clear restarts the count at one.
   always_ff @(posedge clk_i) begin
      if (reset) begin
         dropped_o  <= '0;
         overflow_o <= 1'b0;
      end else if (drop) begin
         overflow_o <= 1'b1;
         if (clear_i) begin
            dropped_o <= 16'd1;
         end else begin
            dropped_o <= (dropped_o == 16'hFFFF) ? dropped_o : dropped_o + 16'd1;
         end
      end else if (clear_i) begin
         dropped_o  <= '0;
         overflow_o <= 1'b0;
      end
   end

   assign level_o = level_q;

endmodule

// File: tb/tb_meas_frame_streamer.sv
// Self-checking bench for meas_frame_streamer (NUM_WORDS=4, FIFO_WORDS=16).
// Expected frames are queued when a tick is driven and compared as words leave the stream.
// Table-driven tick sequence plus hand-written backpressure, clear, reset and saturation cases.
module tb_meas_frame_streamer;

   localparam int NW = 4;
   localparam int FW = 16;

   logic         clk_i = 1'b0;
   logic         reset;
   logic         tick_i;
   logic [31:0]  counter_i;
   logic [127:0] data_i;
   logic [31:0]  m_data_o;
   logic         m_valid_o;
   logic         m_ready_i;
   logic         m_last_o;
   logic         clear_i;
   logic         overflow_o;
   logic [15:0]  dropped_o;
   logic [4:0]   level_o;

   typedef struct {
      int           gap;
      logic [31:0]  cnt;
      logic [127:0] dat;
      bit           acc;
      logic [15:0]  drops;
      bit           ovf;
   } vec_t;

   vec_t         vecs [8];
   logic [32:0]  exp_q [$];
   logic [15:0]  exp_seq;
   int           total, bad, words_seen, lasts_seen, ws, ls, n;
   bit           rand_rdy, stall_prev;
   logic [32:0]  stall_val, e;
   logic [31:0]  c;
   logic [127:0] d;

   meas_frame_streamer #(.NUM_WORDS(NW), .FIFO_WORDS(FW)) dut (
      .clk_i      (clk_i),
      .reset      (reset),
      .tick_i     (tick_i),
      .counter_i  (counter_i),
      .data_i     (data_i),
      .m_data_o   (m_data_o),
      .m_valid_o  (m_valid_o),
      .m_ready_i  (m_ready_i),
      .m_last_o   (m_last_o),
      .clear_i    (clear_i),
      .overflow_o (overflow_o),
      .dropped_o  (dropped_o),
      .level_o    (level_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: bound expired", name);
   endtask

   task automatic cyc(input int k);
      repeat (k) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   // Queue the six words a frame must produce, header carrying the bench's own seq count.
   task automatic push_frame(input logic [31:0] cv, input logic [127:0] dv);
      exp_q.push_back({1'b0, 8'hA5, 8'h04, exp_seq});
      exp_q.push_back({1'b0, cv});
      for (int k = 0; k < NW; k++) begin
         exp_q.push_back({(k == NW - 1), dv[32*k +: 32]});
      end
      exp_seq++;
   endtask

   // Tick is sampled at the first posedge after the call; returns 1ns after that edge.
   task automatic do_tick(input logic [31:0] cv, input logic [127:0] dv);
      tick_i    = 1'b1;
      counter_i = cv;
      data_i    = dv;
      @(posedge clk_i);
      #1;
      tick_i = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 1000) begin
         cyc(1);
         k++;
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);
      cyc(3);
      check("drain_level", 64'(level_o), 64'd0);
   endtask

   initial begin
      total = 0; bad = 0; words_seen = 0; lasts_seen = 0;
      reset = 1'b1; tick_i = 1'b0; clear_i = 1'b0; m_ready_i = 1'b0;
      counter_i = '0; data_i = '0; exp_seq = '0; rand_rdy = 1'b0; stall_prev = 1'b0;

      vecs[0] = '{10, 32'hFFFF_FFFF, {4{32'hFFFF_FFFF}}, 1'b1, 16'd0, 1'b0};
      vecs[1] = '{10, 32'h0000_0000, 128'd0, 1'b1, 16'd0, 1'b0};
      vecs[2] = '{10, 32'hA5A5_A5A5, {32'hAAAA_AAAA, 32'h5555_5555, 32'hDEAD_BEEF, 32'h0123_4567}, 1'b1, 16'd0, 1'b0};
      vecs[3] = '{2,  32'h1234_5678, {4{32'h0BAD_0BAD}}, 1'b0, 16'd1, 1'b1};
      vecs[4] = '{10, 32'h0000_0020, {32'd8, 32'd7, 32'd6, 32'd5}, 1'b1, 16'd1, 1'b1};
      vecs[5] = '{7,  32'h0000_0030, {32'd12, 32'd11, 32'd10, 32'd9}, 1'b1, 16'd1, 1'b1};
      vecs[6] = '{6,  32'h0000_0040, {4{32'hFEED_FACE}}, 1'b0, 16'd2, 1'b1};
      vecs[7] = '{10, 32'h0000_0050, {32'h40, 32'h30, 32'h20, 32'h10}, 1'b1, 16'd2, 1'b1};

      fork
         // Output monitor: scoreboard compare on each handshake, hold check while stalled.
         forever begin
            @(negedge clk_i);
            if (stall_prev) begin
               check("stall_hold", 64'({m_valid_o, m_last_o, m_data_o}), 64'({1'b1, stall_val}));
            end
            if (m_valid_o && m_ready_i && !reset) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_word: got 0x%0h, expected no word", m_data_o);
               end else begin
                  e = exp_q.pop_front();
                  check("stream_word", 64'({m_last_o, m_data_o}), 64'(e));
                  words_seen++;
                  if (m_last_o) lasts_seen++;
               end
            end
            stall_prev = m_valid_o && !m_ready_i && !reset;
            stall_val  = {m_last_o, m_data_o};
         end
         // Random consumer readiness when enabled.
         forever begin
            @(posedge clk_i);
            #1;
            if (rand_rdy) m_ready_i = 1'($urandom_range(0, 1));
         end
         begin
            #500000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "time limit");
         end
      join_none

      // Reset state.
      cyc(3);
      check("rst_valid", 64'(m_valid_o), 64'd0);
      check("rst_last", 64'(m_last_o), 64'd0);
      check("rst_data", 64'(m_data_o), 64'd0);
      check("rst_level", 64'(level_o), 64'd0);
      check("rst_dropped", 64'(dropped_o), 64'd0);
      check("rst_overflow", 64'(overflow_o), 64'd0);
      reset = 1'b0;
      m_ready_i = 1'b1;
      cyc(2);

      // Single frame latency: header valid two cycles after the tick edge.
      push_frame(32'h10, {32'd4, 32'd3, 32'd2, 32'd1});
      do_tick(32'h10, {32'd4, 32'd3, 32'd2, 32'd1});
      @(negedge clk_i);
      check("lat_t0_valid", 64'(m_valid_o), 64'd0);
      @(negedge clk_i);
      check("lat_t1_valid", 64'(m_valid_o), 64'd0);
      check("lat_t1_level", 64'(level_o), 64'd1);
      @(negedge clk_i);
      check("lat_t2_header", 64'({m_valid_o, m_data_o}), 64'({1'b1, 32'hA504_0000}));

      // Table of tick patterns, including ticks landing inside a frame write.
      for (int i = 0; i < 8; i++) begin
         cyc(vecs[i].gap - 1);
         if (vecs[i].acc) push_frame(vecs[i].cnt, vecs[i].dat);
         do_tick(vecs[i].cnt, vecs[i].dat);
         @(negedge clk_i);
         check($sformatf("vec%0d_dropped", i), 64'(dropped_o), 64'(vecs[i].drops));
         check($sformatf("vec%0d_overflow", i), 64'(overflow_o), 64'(vecs[i].ovf));
      end
      drain();

      // Backpressure: two frames fit, the third is dropped.
      reset = 1'b1;
      m_ready_i = 1'b0;
      cyc(1);
      reset = 1'b0;
      exp_seq = '0;
      for (int i = 0; i < 3; i++) begin
         c = 32'h100 + 32'(i);
         d = {$urandom, $urandom, $urandom, $urandom};
         if (i < 2) push_frame(c, d);
         do_tick(c, d);
         cyc(9);
      end
      check("bp_level", 64'(level_o), 64'd12);
      check("bp_dropped", 64'(dropped_o), 64'd1);
      check("bp_overflow", 64'(overflow_o), 64'd1);
      ws = words_seen;
      ls = lasts_seen;
      m_ready_i = 1'b1;
      drain();
      check("bp_words", 64'(words_seen - ws), 64'd12);
      check("bp_lasts", 64'(lasts_seen - ls), 64'd2);

      // Drop in the same cycle as clear, then clear alone.
      push_frame(32'h200, {4{32'h0000_0200}});
      do_tick(32'h200, {4{32'h0000_0200}});
      cyc(1);
      clear_i = 1'b1;
      do_tick(32'h201, {4{32'h0000_0201}});
      clear_i = 1'b0;
      @(negedge clk_i);
      check("clr_drop_dropped", 64'(dropped_o), 64'd1);
      check("clr_drop_overflow", 64'(overflow_o), 64'd1);
      cyc(1);
      clear_i = 1'b1;
      cyc(1);
      clear_i = 1'b0;
      @(negedge clk_i);
      check("clr_dropped", 64'(dropped_o), 64'd0);
      check("clr_overflow", 64'(overflow_o), 64'd0);
      drain();

      // Reset three cycles after an accepted tick discards the partial frame.
      m_ready_i = 1'b0;
      do_tick(32'h77, {4{32'h7777_7777}});
      cyc(2);
      reset = 1'b1;
      @(negedge clk_i);
      check("wrst_pre_level", 64'(level_o), 64'd2);
      cyc(1);
      reset = 1'b0;
      check("wrst_valid", 64'(m_valid_o), 64'd0);
      check("wrst_level", 64'(level_o), 64'd0);
      exp_seq = '0;
      m_ready_i = 1'b1;
      cyc(2);
      push_frame(32'h55, {32'd44, 32'd33, 32'd22, 32'd11});
      do_tick(32'h55, {32'd44, 32'd33, 32'd22, 32'd11});
      drain();

      // 200 frames with a randomly stalling consumer.
      rand_rdy = 1'b1;
      for (int f = 0; f < 200; f++) begin
         n = 0;
         cyc(6);
         while (exp_q.size() > 9 && n < 300) begin
            cyc(1);
            n++;
         end
         if (n >= 300) begin
            fail_now("rand_space_wait");
            break;
         end
         c = $urandom;
         d = {$urandom, $urandom, $urandom, $urandom};
         push_frame(c, d);
         do_tick(c, d);
      end
      drain();
      rand_rdy = 1'b0;
      m_ready_i = 1'b1;
      check("rand_dropped", 64'(dropped_o), 64'd0);

      // Drop counter saturation.
      force dut.dropped_o = 16'hFFFF;
      push_frame(32'h300, {4{32'h0000_0300}});
      do_tick(32'h300, {4{32'h0000_0300}});
      cyc(1);
      do_tick(32'h301, {4{32'h0000_0301}});
      release dut.dropped_o;
      @(negedge clk_i);
      check("sat_dropped", 64'(dropped_o), 64'hFFFF);
      check("sat_overflow", 64'(overflow_o), 64'd1);
      cyc(10);
      push_frame(32'h302, {4{32'h0000_0302}});
      do_tick(32'h302, {4{32'h0000_0302}});
      cyc(1);
      do_tick(32'h303, {4{32'h0000_0303}});
      @(negedge clk_i);
      check("sat_hold", 64'(dropped_o), 64'hFFFF);
      cyc(1);
      clear_i = 1'b1;
      cyc(1);
      clear_i = 1'b0;
      @(negedge clk_i);
      check("sat_clr_dropped", 64'(dropped_o), 64'd0);
      check("sat_clr_overflow", 64'(overflow_o), 64'd0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
